// File: rtl/fetch_pkg.sv
// Shared types and sizing helpers for the prefetching fetch stage.
package fetch_pkg;

    localparam int FETCH_XLEN  = 32;
    localparam int INSTR_BYTES = 4;

    // One buffered fetch result; the FIFO word packs pc in the upper half.
    typedef struct packed {
        logic [FETCH_XLEN-1:0] pc;
        logic [FETCH_XLEN-1:0] instr;
    } fetch_entry_t;

    function automatic int fetch_cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    localparam int FETCH_DEF_DEPTH = 4;
    localparam int FETCH_DEF_CNT_W = fetch_cnt_w(FETCH_DEF_DEPTH);

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with flush; wrap is tracked with an extra pointer MSB.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: it is only observed through a non-empty head.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count   = CW'(wr_ptr - rd_ptr);
    assign rd_data = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Prefetching fetch stage: credit-limited imem requests, stale-response discard on redirect.
// Optional FETCH_PERF_EN adds saturating bubble/discard counters.
module fetch_prefetch_unit
    import fetch_pkg::*;
#(
    parameter int               XLEN     = FETCH_XLEN,
    parameter int               DEPTH    = FETCH_DEF_DEPTH,
    parameter logic [XLEN-1:0]  RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instr_data,
    output logic [XLEN-1:0] instr_pc,
    output logic [XLEN-1:0] instr_pc_plus4
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]     perf_bubble_cnt,
    output logic [31:0]     perf_discard_cnt
`endif
);

    localparam int              CW   = fetch_cnt_w(DEPTH);
    localparam int              EW   = 2 * XLEN;
    localparam logic [XLEN-1:0] STEP = XLEN'(INSTR_BYTES);

    // Handshake rule for both channels: a transfer happens on a clock edge where
    // valid && ready; imem responses have no ready and are always taken.
    logic            running;
    logic [XLEN-1:0] req_pc;
    logic [XLEN-1:0] rsp_pc;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   discard_cnt;
    logic [CW-1:0]   fifo_count;
    logic [CW:0]     credit_used;
    logic [XLEN-1:0] target_pc;
    logic            req_fire;
    logic            rsp_drop;
    logic            fifo_push;
    logic            fifo_pop;
    logic            fifo_full;
    logic            fifo_empty;
    logic [EW-1:0]   fifo_head;

    assign target_pc   = {redirect_pc[XLEN-1:2], 2'b00};
    assign credit_used = {1'b0, outstanding} + {1'b0, fifo_count};

    // Held low for the first cycle after reset release so the request path
    // starts from a clean, synchronised state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) running <= 1'b0;
        else        running <= 1'b1;
    end

    assign imem_req_valid = running && !redirect_valid && (credit_used < (CW+1)'(DEPTH));
    assign imem_req_addr  = req_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign rsp_drop  = imem_rsp_valid && (redirect_valid || (discard_cnt != '0));
    assign fifo_push = imem_rsp_valid && !rsp_drop;
    assign fifo_pop  = !fifo_empty && instr_ready && !redirect_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_pc      <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            discard_cnt <= '0;
        end else begin
            outstanding <= outstanding + CW'(req_fire) - CW'(imem_rsp_valid);
            if (redirect_valid) begin
                req_pc      <= target_pc;
                rsp_pc      <= target_pc;
                // Everything still in flight belongs to the old path.
                discard_cnt <= outstanding - CW'(imem_rsp_valid);
            end else begin
                if (req_fire)  req_pc <= req_pc + STEP;
                if (fifo_push) rsp_pc <= rsp_pc + STEP;
                if (imem_rsp_valid && (discard_cnt != '0)) discard_cnt <= discard_cnt - 1'b1;
            end
        end
    end

    sync_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .flush   (redirect_valid),
        .wr_data ({rsp_pc, imem_rsp_data}),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // Head fields are forced to zero while nothing is buffered.
    assign instr_valid    = !fifo_empty;
    assign instr_pc       = instr_valid ? fifo_head[EW-1:XLEN] : '0;
    assign instr_data     = instr_valid ? fifo_head[XLEN-1:0]  : '0;
    assign instr_pc_plus4 = instr_valid ? (instr_pc + STEP)    : '0;

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_bubble_cnt  <= '0;
            perf_discard_cnt <= '0;
        end else begin
            if (!instr_valid && !redirect_valid && (perf_bubble_cnt != '1))
                perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
            if (rsp_drop && (perf_discard_cnt != '1))
                perf_discard_cnt <= perf_discard_cnt + 32'd1;
        end
    end
`endif

    logic unused_full;
    assign unused_full = fifo_full;

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Bench for fetch_prefetch_unit: directed scenarios then random traffic against a queue-based model.
module tb_fetch_prefetch_unit;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_data;
    logic [31:0] instr_pc;
    logic [31:0] instr_pc_plus4;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_bubble_cnt;
    logic [31:0] perf_discard_cnt;
`endif

    fetch_prefetch_unit #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_data     (instr_data),
        .instr_pc       (instr_pc),
        .instr_pc_plus4 (instr_pc_plus4)
`ifdef FETCH_PERF_EN
        ,
        .perf_bubble_cnt  (perf_bubble_cnt),
        .perf_discard_cnt (perf_discard_cnt)
`endif
    );

    // clock / reset
    always #5 clk = ~clk;

    // model state: memory requests in flight and expected FIFO contents (pcs)
    typedef struct {
        logic [31:0] addr;
        int          due;
        int          epoch;
    } mreq_t;

    mreq_t       mq[$];
    logic [31:0] exp_q[$];
    logic [31:0] m_req_pc = 32'h0;
    int          epoch = 0;
    int          cyc = 0;
    int          lat = 1;
    bit          running = 1'b0;
    int          exp_bubble = 0;
    int          exp_disc = 0;

    logic        obs_valid;
    logic        obs_fire;
    logic [31:0] obs_addr;

    int n_cmp = 0;
    int n_fail = 0;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // driver: one clock cycle of stimulus plus model update
    task automatic cycle(input logic redir, input logic [31:0] rpc, input logic rdy, input logic mrdy);
        logic  rv;
        logic  exp_rv;
        int    due;
        mreq_t m;
        @(negedge clk);
        obs_valid = instr_valid;
        chk("instr_valid", 32'(instr_valid), 32'(exp_q.size() > 0));
        if (exp_q.size() > 0) begin
            chk("instr_pc", instr_pc, exp_q[0]);
            chk("instr_data", instr_data, instr_of(exp_q[0]));
            chk("instr_pc_plus4", instr_pc_plus4, exp_q[0] + 32'd4);
        end
        if (exp_q.size() == 0 && !redir) exp_bubble++;
        rv = (mq.size() > 0) && (mq[0].due <= cyc);
        redirect_valid = redir;
        redirect_pc    = rpc;
        instr_ready    = rdy;
        imem_req_ready = mrdy;
        imem_rsp_valid = rv;
        imem_rsp_data  = rv ? instr_of(mq[0].addr) : $urandom();
        #1;
        exp_rv = running && !redir && (mq.size() + exp_q.size() < DEPTH);
        chk("imem_req_valid", 32'(imem_req_valid), 32'(exp_rv));
        if (exp_rv) chk("imem_req_addr", imem_req_addr, m_req_pc);
        obs_fire = imem_req_valid && imem_req_ready;
        obs_addr = imem_req_addr;
        if (!redir && rdy && exp_q.size() > 0) void'(exp_q.pop_front());
        if (rv) begin
            m = mq.pop_front();
            if (!redir && m.epoch == epoch) exp_q.push_back(m.addr);
            else exp_disc++;
        end
        if (redir) begin
            exp_q.delete();
            epoch++;
            m_req_pc = rpc & ~32'd3;
        end else if (exp_rv && mrdy) begin
            due = cyc + lat;
            if (mq.size() > 0 && mq[$].due + 1 > due) due = mq[$].due + 1;
            mq.push_back('{addr: m_req_pc, due: due, epoch: epoch});
            m_req_pc = m_req_pc + 32'd4;
        end
        cyc++;
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_valid"}, 32'(imem_req_valid), 32'd0);
        chk({tag, "_req_addr"}, imem_req_addr, 32'h0);
        chk({tag, "_instr_valid"}, 32'(instr_valid), 32'd0);
        chk({tag, "_instr_data"}, instr_data, 32'h0);
        chk({tag, "_instr_pc"}, instr_pc, 32'h0);
        chk({tag, "_instr_pc_plus4"}, instr_pc_plus4, 32'h0);
    endtask

    task automatic wait_head(input string tag);
        int n = 0;
        while (exp_q.size() == 0 && n < 30) begin
            cycle(1'b0, 32'h0, 1'b0, 1'b1);
            n++;
        end
        chk({tag, "_wait_bound"}, 32'(exp_q.size() > 0), 32'd1);
    endtask

    initial begin : main
        int first_k;
        int fires;
        int n;
        logic [31:0] fire_addrs[$];
        int d0;

        rst_n = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data = 32'h0;
        instr_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        running = 1'b1;
        exp_bubble = 1;

        // 1: reset fetch sequence, 1-cycle memory, always ready
        lat = 1;
        first_k = 0;
        for (int k = 1; k <= 8; k++) begin
            cycle(1'b0, 32'h0, 1'b1, 1'b1);
            if (obs_valid && first_k == 0) first_k = k;
            if (obs_fire) fire_addrs.push_back(obs_addr);
        end
        chk("first_valid_cycles", 32'(first_k), 32'd3);
        chk("fire_count_min", 32'(fire_addrs.size() >= 3), 32'd1);
        if (fire_addrs.size() >= 3) begin
            chk("req_addr_0", fire_addrs[0], 32'h0);
            chk("req_addr_1", fire_addrs[1], 32'h4);
            chk("req_addr_2", fire_addrs[2], 32'h8);
        end

        // 2: decode stalled, credits exhaust at DEPTH, resume at 0x10
        cycle(1'b1, 32'h0, 1'b0, 1'b1);
        fires = 0;
        for (int k = 0; k < 12; k++) begin
            cycle(1'b0, 32'h0, 1'b0, 1'b1);
            if (obs_fire) fires++;
        end
        chk("stall_fire_count", 32'(fires), 32'd4);
        n = 0;
        do begin
            cycle(1'b0, 32'h0, 1'b1, 1'b1);
            n++;
        end while (!obs_fire && n < 8);
        chk("resume_fired", 32'(obs_fire), 32'd1);
        chk("resume_addr", obs_addr, 32'h10);

        // 3: 3-cycle memory, redirect with three requests in flight
        lat = 3;
        n = 0;
        while (mq.size() != 3 && n < 30) begin
            cycle(1'b0, 32'h0, 1'b1, 1'b1);
            n++;
        end
        chk("reach_3_outstanding", 32'(mq.size()), 32'd3);
        d0 = exp_disc;
        cycle(1'b1, 32'h100, 1'b1, 1'b1);
        wait_head("redir100");
        settle();
        chk("redir100_pc", instr_pc, 32'h100);
        chk("redir100_dropped", 32'(exp_disc - d0), 32'd3);
`ifdef FETCH_PERF_EN
        chk("perf_discard_3", perf_discard_cnt - 32'(d0), 32'd3);
`endif

        // 4: redirect coinciding with a response and a pop
        lat = 1;
        n = 0;
        while (!(exp_q.size() > 0 && mq.size() > 0 && mq[0].due <= cyc) && n < 20) begin
            cycle(1'b0, 32'h0, 1'b1, 1'b1);
            n++;
        end
        chk("coincide_setup", 32'(exp_q.size() > 0 && mq.size() > 0), 32'd1);
        cycle(1'b1, 32'h200, 1'b1, 1'b1);
        cycle(1'b0, 32'h0, 1'b1, 1'b1);
        chk("coincide_fifo_empty", 32'(obs_valid), 32'd0);
        chk("coincide_fire", 32'(obs_fire), 32'd1);
        chk("coincide_addr", obs_addr, 32'h200);

        // 5: misaligned redirect target
        cycle(1'b1, 32'h102, 1'b1, 1'b1);
        wait_head("redir102");
        settle();
        chk("redir102_pc", instr_pc, 32'h100);

        // 6: wrap at the top of the address space
        cycle(1'b1, 32'hFFFF_FFFC, 1'b1, 1'b1);
        wait_head("wrap");
        settle();
        chk("wrap_pc", instr_pc, 32'hFFFF_FFFC);
        chk("wrap_plus4", instr_pc_plus4, 32'h0);
        cycle(1'b0, 32'h0, 1'b1, 1'b1);
        wait_head("wrap_next");
        settle();
        chk("wrap_next_pc", instr_pc, 32'h0);

        // 7: asynchronous reset mid-burst with two requests outstanding
        lat = 3;
        cycle(1'b1, 32'h300, 1'b0, 1'b1);
        n = 0;
        while (mq.size() != 2 && n < 20) begin
            cycle(1'b0, 32'h0, 1'b0, 1'b1);
            n++;
        end
        chk("reach_2_outstanding", 32'(mq.size()), 32'd2);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        imem_rsp_valid = 1'b0;
        redirect_valid = 1'b0;
        #1;
        chk_reset_outputs("midreset");
        mq.delete();
        exp_q.delete();
        epoch++;
        m_req_pc = 32'h0;
        running = 1'b0;
        exp_bubble = 0;
        exp_disc = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        running = 1'b1;
        exp_bubble = 1;
        lat = 1;
        for (int k = 0; k < 8; k++) cycle(1'b0, 32'h0, 1'b1, 1'b1);

        // random traffic
        for (int k = 0; k < 900; k++) begin
            if (k % 100 == 0) lat = $urandom_range(1, 3);
            if ($urandom_range(0, 15) == 0)
                cycle(1'b1, $urandom(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0));
            else
                cycle(1'b0, 32'h0, 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 3) != 0));
        end
        settle();
`ifdef FETCH_PERF_EN
        chk("perf_bubble_final", perf_bubble_cnt, 32'(exp_bubble));
        chk("perf_discard_final", perf_discard_cnt, 32'(exp_disc));
`endif

        // final report
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/fetch_prefetch_unit.md
Name: fetch_prefetch_unit

Overview:
- Parametrised successor to the single-cycle fetch stage.
- Decouples the pipeline from a variable-latency instruction memory using a valid/ready request channel, an in-order response channel, and a prefetch FIFO of DEPTH entries.
- Handles redirects (branch/jump from Execute) by discarding in-flight stale responses.
- Feeds the decode stage through a valid/ready instruction interface that replaces the stall/flush wires.

Parameters:
- XLEN, 32, instruction/PC width.
- DEPTH, 4, prefetch FIFO entries; also the cap on outstanding requests plus buffered entries (power of two, >=2).
- RESET_PC, 32'h0000_0000, PC value after reset.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- redirect_valid  in  1  pipeline redirect (PCSrcE-equivalent).
- redirect_pc  in  XLEN  redirect target; bits [1:0] ignored, treated as 0.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  XLEN  request address.
- imem_rsp_valid  in  1  in-order response valid; always accepted.
- imem_rsp_data  in  XLEN  fetched instruction.
- instr_valid  out  1  FIFO head valid to decode.
- instr_ready  in  1  decode accepts the head.
- instr_data  out  XLEN  head instruction.
- instr_pc  out  XLEN  head PC.
- instr_pc_plus4  out  XLEN  head PC + 4.

Behaviour:
- Reset (asynchronous, any time, including mid-transaction):
  - req_pc = rsp_pc = RESET_PC.
  - outstanding = discard_cnt = fifo count = 0.
  - imem_req_valid = 0, instr_valid = 0; data outputs 0.
- Credit rule:
  - imem_req_valid = !redirect_valid && (outstanding + fifo_count < DEPTH).
  - imem_req_addr = req_pc.
- A request handshake (valid && ready) increments outstanding and advances req_pc by 4; wraps mod 2^XLEN.
- Response handling, when imem_rsp_valid is high:
  - Outstanding decrements.
  - If discard_cnt > 0: drop the response and decrement discard_cnt.
  - Otherwise: push {rsp_pc, data} into the FIFO and advance rsp_pc by 4.
  - The reservation guarantees the FIFO never overflows.
- instr_valid = FIFO non-empty; it is registered state, with no combinational path from the memory response.
- A pop occurs on instr_valid && instr_ready.
- instr_pc_plus4 = instr_pc + 4, wrapping.
- Redirect (redirect_valid = 1, single-cycle pulse or held):
  - No request is issued that cycle; the combinational suppression of req_valid is intentional.
  - FIFO flushed; a pop in the same cycle is ignored.
  - req_pc and rsp_pc both load {redirect_pc[XLEN-1:2], 2'b00}.
  - discard_cnt loads outstanding minus (imem_rsp_valid ? 1 : 0); the response arriving in the redirect cycle is dropped.
  - outstanding updates normally.
- Latency with a 1-cycle memory: redirect at N, request at N+1, response at N+2, instr_valid at N+3.
- Simultaneous push and pop: both occur, and count is unchanged.
- Full FIFO with instr_ready = 0: no new requests are issued. Credits reopen the cycle after a pop.
- A back-to-back redirect while discard_cnt > 0 recomputes discard_cnt from outstanding (it is a superset).
- imem_req_addr is held stable while imem_req_valid && !imem_req_ready.

Optional Feature:
- Macro FETCH_PERF_EN.
- When defined:
  - Adds outputs perf_bubble_cnt (32) and perf_discard_cnt (32).
  - perf_bubble_cnt counts cycles with instr_valid = 0 and no redirect.
  - perf_discard_cnt counts dropped responses.
  - Both saturate at all-ones and reset to 0.
- When undefined: the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package fetch_pkg holds:
  - typedef fetch_entry_t (packed struct {pc, instr}).
  - Constant INSTR_BYTES = 4.
  - Helper localparam for counter width ($clog2(DEPTH+1)).
- Sub-module sync_fifo (parametrised WIDTH/DEPTH):
  - Ports push, pop, flush, full, empty, count, data.
  - Pointer wrap handled via an extra MSB.
- Top-level logic owns the credit, discard, and PC logic.

Test Plan:
- Reset, with imem always ready and 1-cycle response:
  - imem_req_addr sequence 0x0, 0x4, 0x8.
  - instr_valid first rises 3 cycles after rst_n deasserts.
  - instr_pc follows 0x0, 0x4, 0x8 with matching data.
- instr_ready held at 0, DEPTH = 4:
  - Exactly 4 requests are issued, then imem_req_valid stays 0.
  - Release ready: entries 0x0–0xC pop in order and requests resume at 0x10.
- Memory latency 3 cycles with 3 outstanding, then redirect to 0x100:
  - All 3 stale responses are dropped.
  - First delivered instr_pc = 0x100; perf_discard_cnt = 3 if enabled.
- Redirect in the same cycle as imem_rsp_valid and an instr_ready pop:
  - FIFO empties and that response is dropped.
  - Next request address is the redirect target.
- Redirect to 0x102:
  - Fetch proceeds from 0x100.
- Redirect to 0xFFFF_FFFC:
  - Fetches 0xFFFF_FFFC then 0x0.
  - instr_pc_plus4 = 0x0 at the wrap.
- Assert rst_n low mid-burst with 2 outstanding:
  - All outputs go to reset values immediately.
  - Late responses after reset are treated per fresh state; the bench must not drive stale responses.
